mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch requester (read-only) and its data-memory stage requester (read/write).
- Sequences each access through a small FSM, returns read data with a one-cycle ack, and drives per-port stall signals so the PC and the IF/ID register can be frozen while an access is pending.
- Sits between the IF/MEM stages and the unified memory model.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles after the enable strobe; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_req_i  in  1  instruction read request
- i_addr_i  in  ADDR_W  instruction address
- i_flush_i  in  1  pipeline flush (branch/jump taken); kills an in-flight instruction access
- i_ack_o  out  1  one-cycle pulse, instruction data valid
- i_rdata_o  out  DATA_W  instruction read data
- i_stall_o  out  1  i_req_i && !i_ack_o
- d_req_i  in  1  data request
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_ack_o  out  1  one-cycle pulse, data access complete
- d_rdata_o  out  DATA_W  data read data
- d_stall_o  out  1  d_req_i && !d_ack_o
- mem_en_o  out  1  memory strobe, one cycle per access
- mem_we_o  out  1  write enable, qualified by mem_en_o
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en_o cycle

Behaviour:
- Clock and reset: single clock clk_i; reset is synchronous and active-low on rst_n.
- Reset values (rst_n=0 at an edge):
  - state=IDLE; last_grant=INSTR; kill=0.
  - All *_ack_o, mem_en_o and mem_we_o are 0.
  - mem_addr_o, mem_wdata_o, i_rdata_o and d_rdata_o are 0.
- Reset mid-access: the access is abandoned, no ack is issued, and mem_en_o is 0 from the next cycle.
- Requester rule:
  - Hold req and its addr/we/wdata stable until the ack cycle.
  - Deasserting req early is illegal, except i_req_i after i_flush_i.
  - The arbiter latches addr/we/wdata at grant; later input changes are ignored.
- FSM states:
  - IDLE: arbitrate. Data wins if d_req_i && (!i_req_i || last_grant==INSTR). Otherwise instruction wins if i_req_i. Otherwise stay in IDLE. On a grant: latch the request, set last_grant, go to ISSUE.
  - ISSUE (1 cycle): mem_en_o=1; mem_we_o = latched we (always 0 for an instruction grant); mem_addr_o/mem_wdata_o = latched values. Load cnt=MEM_LAT and go to WAIT.
  - WAIT (MEM_LAT cycles): decrement cnt. In the cycle cnt==1, capture mem_rdata_i into the granted port's rdata register (reads only; writes leave d_rdata_o unchanged), then go to RESP.
  - RESP (1 cycle): the granted port's ack=1, unless this is an instruction grant with kill==1 or i_flush_i==1. Clear kill and go to IDLE.
- Kill: i_flush_i=1 during ISSUE/WAIT/RESP of an instruction grant sets kill. The memory access still completes (no abort), and i_ack_o is suppressed. i_flush_i has no effect on data grants or in IDLE.
- Latency: request seen in IDLE at cycle 0 → mem_en_o at cycle 1 → ack at cycle 2+MEM_LAT. Back-to-back service period is 3+MEM_LAT cycles (RESP always returns to IDLE, so a stale req is never regranted).
- Fairness: when both ports request continuously, grants alternate D, I, D, I… No port waits more than one other access.
- rdata outputs hold their value until the next capture for that port.
- mem_addr_o/mem_wdata_o hold their last value outside ISSUE.
- Stall outputs are combinational; the ack cycle releases the stall in that same cycle.

Test Plan:
- Single instruction read, MEM_LAT=1, i_addr_i=0x40, memory returns 0x8C010004 → mem_en_o at cycle 1 with mem_addr_o=0x40, mem_we_o=0; i_ack_o at cycle 3 with i_rdata_o=0x8C010004; i_stall_o high in cycles 0–2, low in cycle 3.
- Data write: d_we_i=1, d_addr_i=0x10, d_wdata_i=0xDEADBEEF → one mem_en_o cycle with mem_we_o=1, addr 0x10, data 0xDEADBEEF; d_ack_o at cycle 3; d_rdata_o unchanged.
- Both requests held from reset → grant order D, I, D, I. Acks at cycles 3 (d), 7 (i), 11 (d), 15 (i), with exactly one mem_en_o per 4-cycle period.
- i_flush_i pulsed in the WAIT cycle of an instruction read → mem_en_o still issued, i_ack_o never asserted. The IF requester then issues new address 0x80, which is serviced normally with ack 4 cycles after the request.
- MEM_LAT=3, data read of 0x20 returning 0x12345678 → ack at cycle 5 with d_rdata_o=0x12345678. A mem_rdata_i value driven one cycle earlier must not be captured.
- rst_n=0 asserted during WAIT → next cycle state is IDLE, no ack ever issued, all outputs at reset values. The held request is regranted after rst_n=1 with normal timing.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : IF/MEM requester ports plus the shared memory port of the arbiter
//  Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_flush_i;
    logic              i_ack_o;
    logic [DATA_W-1:0] i_rdata_o;
    logic              i_stall_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_stall_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  i_req_i, i_addr_i, i_flush_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
        output i_ack_o, i_rdata_o, i_stall_o, d_ack_o, d_rdata_o, d_stall_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output i_req_i, i_addr_i, i_flush_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_rdata_i,
        input  i_ack_o, i_rdata_o, i_stall_o, d_ack_o, d_rdata_o, d_stall_o,
               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin share of one fixed-latency memory between IF and MEM
//  Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  wire logic          clk_i,
    input  wire logic          rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [3:0] c_LAT_LOAD = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_data_q, gnt_data_d;
    logic                last_data_q, last_data_d;
    logic                we_q, we_d;
    logic                kill_q, kill_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            we_q        <= 1'b0;
            kill_q      <= 1'b0;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            we_q        <= we_d;
            kill_q      <= kill_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        we_d        = we_q;
        kill_d      = kill_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        // A flush only poisons the ack; the memory transaction itself runs to completion.
        if (state_q != S_IDLE && !gnt_data_q && bus.i_flush_i)
            kill_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.d_req_i && (!bus.i_req_i || !last_data_q)) begin
                    gnt_data_d  = 1'b1;
                    last_data_d = 1'b1;
                    we_d        = bus.d_we_i;
                    addr_d      = bus.d_addr_i;
                    wdata_d     = bus.d_wdata_i;
                    state_d     = S_ISSUE;
                end else if (bus.i_req_i) begin
                    gnt_data_d  = 1'b0;
                    last_data_d = 1'b0;
                    we_d        = 1'b0;
                    addr_d      = bus.i_addr_i;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = c_LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!gnt_data_q)
                        i_rdata_d = bus.mem_rdata_i;
                    else if (!we_q)
                        d_rdata_d = bus.mem_rdata_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_en_o    = (state_q == S_ISSUE);
    assign bus.mem_we_o    = (state_q == S_ISSUE) && we_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

    assign bus.i_ack_o   = (state_q == S_RESP) && !gnt_data_q && !kill_q && !bus.i_flush_i;
    assign bus.d_ack_o   = (state_q == S_RESP) && gnt_data_q;
    assign bus.i_rdata_o = i_rdata_q;
    assign bus.d_rdata_o = d_rdata_q;
    assign bus.i_stall_o = bus.i_req_i && !bus.i_ack_o;
    assign bus.d_stall_o = bus.d_req_i && !bus.d_ack_o;

endmodule
`default_nettype wire
